// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen -- programmable PWM generator with a double-buffered configuration.
//
// A period counter runs while enabled and produces a registered PWM waveform
// that is high for act_high clocks and low for the rest of act_period clocks.
// New settings arrive through a valid/ready handshake into a shadow register
// and are only promoted to the active pair at a period boundary (counter wrap)
// or on the transition from IDLE into RUN, so a period is never torn.
//
// Parameters
//   CNT_WIDTH      width of the counter and of every configuration value
//   DEFAULT_PERIOD active period (clocks) after reset
//   DEFAULT_HIGH   active high time (clocks) after reset
//
// Ports
//   pwd_clk       in   single clock, rising-edge
//   sysreset      in   asynchronous, active-high reset
//   enable        in   run request; low forces IDLE
//   cfg_period    in   requested period in clocks (0/1 are clamped to 2)
//   cfg_high      in   requested high time in clocks
//   cfg_valid     in   configuration offer
//   cfg_ready     out  shadow register empty; transfer = cfg_valid & cfg_ready
//   pwm_out       out  registered PWM waveform
//   period_start  out  one-cycle pulse in the first cycle of every period
//   cfg_applied   out  one-cycle pulse when the shadow becomes active
// -----------------------------------------------------------------------------
module pwm_gen #(
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned DEFAULT_PERIOD = 1000,
    parameter int unsigned DEFAULT_HIGH   = 500
) (
    input  logic                 pwd_clk,
    input  logic                 sysreset,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_high,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 pwm_out,
    output logic                 period_start,
    output logic                 cfg_applied
);

    localparam logic [CNT_WIDTH-1:0] ZERO       = '0;
    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO        = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] DEF_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] DEF_HIGH   = CNT_WIDTH'(DEFAULT_HIGH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Registered state
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] act_period;
    logic [CNT_WIDTH-1:0] act_high;
    logic [CNT_WIDTH-1:0] shd_period;
    logic [CNT_WIDTH-1:0] shd_high;
    logic                 pending;

    // Next-state values
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH-1:0] act_period_next;
    logic [CNT_WIDTH-1:0] act_high_next;
    logic [CNT_WIDTH-1:0] shd_period_next;
    logic [CNT_WIDTH-1:0] shd_high_next;
    logic                 pending_next;
    logic                 pwm_next;
    logic                 period_start_next;
    logic                 cfg_applied_next;

    // Handshake and capture helpers
    logic                 transfer;
    logic                 wrap;
    logic                 apply;
    logic                 period_clamp;
    logic [CNT_WIDTH-1:0] cap_period;
    logic [CNT_WIDTH-1:0] cap_high;

    assign cfg_ready = ~pending;
    assign transfer  = cfg_valid & ~pending;

    // cnt never exceeds act_period-1 and act_period is always >= 2, so the
    // subtraction cannot underflow.
    assign wrap = (cnt == act_period - ONE);

    // Periods of 0 or 1 are widened to 2. A requested high time of 1 on such
    // a period already covered the whole period, so it is widened with it to
    // keep the output constant high; a high time of 0 stays constant low.
    assign period_clamp = (cfg_period < TWO);
    assign cap_period   = period_clamp ? TWO : cfg_period;
    assign cap_high     = (period_clamp && (cfg_high == ONE)) ? TWO : cfg_high;

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path can leave one
        // unassigned, which would otherwise infer a latch.
        state_next        = state;
        cnt_next          = cnt;
        act_period_next   = act_period;
        act_high_next     = act_high;
        shd_period_next   = shd_period;
        shd_high_next     = shd_high;
        pending_next      = pending;
        pwm_next          = 1'b0;
        period_start_next = 1'b0;
        cfg_applied_next  = 1'b0;
        apply             = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = ZERO;
                if (enable) begin
                    state_next        = RUN;
                    apply             = pending;
                    period_start_next = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Partial period is abandoned; the shadow is kept.
                    state_next = IDLE;
                    cnt_next   = ZERO;
                end else if (wrap) begin
                    cnt_next          = ZERO;
                    apply             = pending;
                    period_start_next = 1'b1;
                end else begin
                    cnt_next = cnt + ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = ZERO;
            end
        endcase

        // apply needs pending=1 and transfer needs pending=0, so they never
        // coincide; a transfer landing on a wrap edge is therefore only seen
        // at the following wrap.
        if (apply) begin
            act_period_next  = shd_period;
            act_high_next    = shd_high;
            pending_next     = 1'b0;
            cfg_applied_next = 1'b1;
        end

        if (transfer) begin
            shd_period_next = cap_period;
            shd_high_next   = cap_high;
            pending_next    = 1'b1;
        end

        // Compared against the values that will be active next cycle, so the
        // registered output lines up with the registered counter. With
        // act_high >= act_period the compare is true for every cnt, giving a
        // glitch-free constant high across the wrap.
        if (state_next == RUN) begin
            pwm_next = (cnt_next < act_high_next);
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values computed before the edge.
    // NOTE: the shadow pair is reset as well even though pending=0 already
    // masks it, so no unknown value can ever reach the active pair.
    always_ff @(posedge pwd_clk or posedge sysreset) begin
        if (sysreset) begin
            state        <= IDLE;
            cnt          <= ZERO;
            act_period   <= DEF_PERIOD;
            act_high     <= DEF_HIGH;
            shd_period   <= DEF_PERIOD;
            shd_high     <= DEF_HIGH;
            pending      <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            cfg_applied  <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            act_period   <= act_period_next;
            act_high     <= act_high_next;
            shd_period   <= shd_period_next;
            shd_high     <= shd_high_next;
            pending      <= pending_next;
            pwm_out      <= pwm_next;
            period_start <= period_start_next;
            cfg_applied  <= cfg_applied_next;
        end
    end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 CNT_WIDTH, default 32: width of the period counter and of all configuration values.
REQ-002 DEFAULT_PERIOD, default 1000: active period in clocks after reset.
REQ-003 DEFAULT_HIGH, default 500: active high time in clocks after reset.
REQ-004 pwd_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 sysreset  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  run request; low forces idle.
REQ-007 cfg_period  input  CNT_WIDTH  requested period in clocks.
REQ-008 cfg_high  input  CNT_WIDTH  requested high time in clocks.
REQ-009 cfg_valid  input  1  config offer; transfer occurs when cfg_valid and cfg_ready are both high.
REQ-010 cfg_ready  output  1  shadow register empty, can accept a config.
REQ-011 pwm_out  output  1  registered PWM waveform that feeds the pulse-width detector.
REQ-012 period_start  output  1  one-cycle pulse, high in the first cycle of every period.
REQ-013 cfg_applied  output  1  one-cycle pulse when the shadow config becomes active.

Function
REQ-014 The block SHALL hold an active pair (act_period, act_high), a shadow pair, a pending flag and a counter cnt.
REQ-015 The FSM SHALL have two states: IDLE and RUN.
REQ-016 IDLE: cnt=0, pwm_out=0; when enable=1, go to RUN.
REQ-017 IDLE->RUN transition: load the pending shadow into active, if any.
REQ-018 RUN: cnt SHALL increment each cycle and wrap to 0 when cnt == act_period-1.
REQ-019 pwm_out SHALL be registered, equal to (cnt_next < act_high), so it goes high in the first RUN cycle when act_high>0.
REQ-020 act_high=0 SHALL give constant low; act_high >= act_period SHALL give constant high with no glitch at wrap.
REQ-021 A period value of 0 or 1 SHALL be clamped to 2 when it is captured into the shadow register.
REQ-022 cfg_ready SHALL equal ~pending.
REQ-023 On a transfer, the shadow SHALL capture cfg_period and cfg_high, and pending SHALL set.
REQ-024 Pending shadow SHALL be copied into active only at a wrap (cnt returning to 0) or at IDLE->RUN, never mid-period.
REQ-025 The same cycle as the copy SHALL clear pending and pulse cfg_applied.
REQ-026 A transfer in the same cycle as a wrap SHALL NOT be applied at that wrap; it SHALL apply at the next wrap.
REQ-027 period_start SHALL pulse on the cycle pwm_out reflects cnt=0, both on entry to RUN and on every wrap.
REQ-028 enable falling in RUN: next cycle SHALL be IDLE with pwm_out=0 and cnt=0.
REQ-029 On enable falling, the partial period SHALL be abandoned, and any pending config SHALL be retained.
REQ-030 All arithmetic SHALL be unsigned CNT_WIDTH, with no overflow of cnt possible since cnt < act_period.
REQ-031 Without a new config, the output SHALL be exactly periodic: high act_high clocks, low act_period-act_high clocks.

Reset
REQ-032 sysreset high SHALL immediately (asynchronously) force:
- state=IDLE
- cnt=0
- pwm_out=0
- period_start=0
- cfg_applied=0
- pending=0 (so cfg_ready=1)
- act_period=DEFAULT_PERIOD, act_high=DEFAULT_HIGH
REQ-033 Reset asserted mid-period SHALL discard any pending config.
REQ-034 After reset is released with enable=1, the first RUN cycle SHALL occur on the second rising edge.

Verification
REQ-035 Reset release, enable=1, defaults -> pwm_out high 500 clocks, low 500, with period_start every 1000 clocks.
REQ-036 Mid-period transfer {period=10, high=3} -> cfg_ready=0 until the wrap; then cfg_applied pulses and the next period is 3 high / 7 low.
REQ-037 cfg_high=0, then cfg_high=12 with period=10 -> constant low, then constant high; period_start is still every 10 clocks.
REQ-038 cfg_period=1, high=1 -> clamped to 2; output is constant high with period_start every 2 clocks.
REQ-039 Transfer on the exact wrap cycle -> old config is kept for one more full period, then the new config applies.
REQ-040 enable dropped at cnt=4 of a 10-clock period, pending config present -> pwm_out=0 next cycle; on re-enable the pending config is active from the first cycle.
REQ-041 sysreset pulsed mid-high-phase -> pwm_out low without a clock edge, and defaults are restored.
